// File: rtl/ultrasonic_scanner.sv
// Scans NUM_SENSORS muxed ultrasonic rangers: trigger, time the echo in microsecond ticks, report one sample per sensor.
// Latency: echo_rx falling edge to dist_valid is 3 clk edges; one report per GAP+TRIG+echo period.
// Backpressure: none; dist_valid is a single-cycle strobe and the data outputs hold until the next report.
module ultrasonic_scanner #(
    parameter int NUM_SENSORS = 4,
    parameter int TICK_DIV    = 50,
    parameter int TRIG_CYCLES = 500,
    parameter int TIMEOUT_US  = 30000,
    parameter int GAP_CYCLES  = 3000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        echo_rx,
    output logic        trig_tx,
    output logic [3:0]  mux_sensor_select,
    output logic        dist_valid,
    output logic [3:0]  dist_sensor,
    output logic [15:0] dist_us,
    output logic        dist_timeout,
    output logic        busy
);

    localparam int CNT_MAX = (GAP_CYCLES > TRIG_CYCLES) ? GAP_CYCLES : TRIG_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PRE_W   = $clog2(TICK_DIV + 1);

    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [15:0]      TO_MAX    = 16'(TIMEOUT_US);
    localparam logic [15:0]      TO_LAST   = 16'(TIMEOUT_US - 1);
    localparam logic [3:0]       IDX_LAST  = 4'(NUM_SENSORS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GAP,
        S_TRIG,
        S_WAIT,
        S_MEAS,
        S_REPORT
    } state_t;

    state_t             state, state_nxt;
    logic               echo_m, echo_s, echo_d;
    logic               echo_rise;
    logic [CNT_W-1:0]   cnt;
    logic [PRE_W-1:0]   presc;
    logic [15:0]        ticks;
    logic [3:0]         idx;
    logic               tick_done;
    logic [15:0]        rpt_us;
    logic               rpt_to;

    assign echo_rise         = echo_s && !echo_d;
    assign tick_done         = (presc == PRE_LAST);
    assign mux_sensor_select = idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_m <= 1'b0;
            echo_s <= 1'b0;
            echo_d <= 1'b0;
        end else begin
            echo_m <= echo_rx;
            echo_s <= echo_m;
            echo_d <= echo_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rpt_us    = '0;
        rpt_to    = 1'b0;
        case (state)
            S_IDLE:   if (enable) state_nxt = S_GAP;
            S_GAP:    if (cnt == GAP_LAST) state_nxt = S_TRIG;
            S_TRIG:   if (cnt == TRIG_LAST) state_nxt = S_WAIT;
            S_WAIT: begin
                // A stale-high echo never produces a rise, so it just runs into the timeout.
                if (echo_rise) begin
                    state_nxt = S_MEAS;
                end else if (tick_done && ticks == TO_LAST) begin
                    state_nxt = S_REPORT;
                    rpt_to    = 1'b1;
                end
            end
            S_MEAS: begin
                // The stuck check wins over a falling echo in the same cycle.
                if (ticks == TO_MAX) begin
                    state_nxt = S_REPORT;
                    rpt_us    = TO_MAX;
                    rpt_to    = 1'b1;
                end else if (!echo_s) begin
                    state_nxt = S_REPORT;
                    rpt_us    = ticks;
                end
            end
            S_REPORT: state_nxt = S_GAP;
            default:  state_nxt = S_IDLE;
        endcase
        if (!enable) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            presc <= '0;
            ticks <= '0;
            idx   <= '0;
        end else begin
            if (state_nxt == state && (state == S_GAP || state == S_TRIG)) cnt <= cnt + 1'b1;
            else                                                           cnt <= '0;

            // The rising-edge cycle is prescaler cycle 0, so it already counts toward the first tick.
            if (state == S_WAIT && echo_rise) begin
                presc <= (TICK_DIV == 1) ? '0 : PRE_W'(1);
                ticks <= (TICK_DIV == 1) ? 16'd1 : 16'd0;
            end else if (state == S_WAIT || (state == S_MEAS && echo_s)) begin
                if (tick_done) begin
                    presc <= '0;
                    ticks <= ticks + 16'd1;
                end else begin
                    presc <= presc + 1'b1;
                end
            end else if (state != S_MEAS) begin
                presc <= '0;
                ticks <= '0;
            end

            if (state_nxt == S_IDLE)
                idx <= '0;
            else if (state == S_REPORT && state_nxt == S_GAP)
                idx <= (idx == IDX_LAST) ? 4'd0 : idx + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_tx      <= 1'b0;
            busy         <= 1'b0;
            dist_valid   <= 1'b0;
            dist_sensor  <= '0;
            dist_us      <= '0;
            dist_timeout <= 1'b0;
        end else begin
            trig_tx    <= (state_nxt == S_TRIG);
            busy       <= (state_nxt != S_IDLE);
            dist_valid <= (state_nxt == S_REPORT);
            if (state_nxt == S_REPORT) begin
                dist_sensor  <= idx;
                dist_us      <= rpt_us;
                dist_timeout <= rpt_to;
            end
        end
    end

endmodule

// File: tb/tb_ultrasonic_scanner.sv
// Directed bench for ultrasonic_scanner with small timing parameters; reports are checked by a scoreboard monitor.
module tb_ultrasonic_scanner;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        echo_rx;
    logic        trig_tx;
    logic [3:0]  mux_sensor_select;
    logic        dist_valid;
    logic [3:0]  dist_sensor;
    logic [15:0] dist_us;
    logic        dist_timeout;
    logic        busy;

    ultrasonic_scanner #(
        .NUM_SENSORS(3),
        .TICK_DIV   (4),
        .TRIG_CYCLES(5),
        .TIMEOUT_US (100),
        .GAP_CYCLES (8)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .enable           (enable),
        .echo_rx          (echo_rx),
        .trig_tx          (trig_tx),
        .mux_sensor_select(mux_sensor_select),
        .dist_valid       (dist_valid),
        .dist_sensor      (dist_sensor),
        .dist_us          (dist_us),
        .dist_timeout     (dist_timeout),
        .busy             (busy)
    );

    typedef struct {
        int s;
        int us;
        int to;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    logic prev_valid = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid <= 1'b0;
        end else begin
            if (dist_valid) begin
                chk("valid_back_to_back", int'(prev_valid), 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_report: sensor %0d us %0d timeout %0d with nothing expected",
                             dist_sensor, dist_us, dist_timeout);
                end else begin
                    e = exp_q.pop_front();
                    chk("dist_sensor", int'(dist_sensor), e.s);
                    chk("dist_us", int'(dist_us), e.us);
                    chk("dist_timeout", int'(dist_timeout), e.to);
                end
            end
            prev_valid <= dist_valid;
        end
    end

    task automatic wait_trig(input logic lvl, input int budget, output int n);
        n = 0;
        while (trig_tx !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (trig_tx !== lvl) chk("trig_wait_timeout", int'(trig_tx), int'(lvl));
    endtask

    task automatic wait_valid(input int budget, output int n);
        n = 0;
        while (dist_valid !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (dist_valid !== 1'b1) chk("valid_wait_timeout", int'(dist_valid), 1);
    endtask

    task automatic push(input int s, input int us, input int to);
        exp_t x;
        x.s  = s;
        x.us = us;
        x.to = to;
        exp_q.push_back(x);
    endtask

    task automatic echo_pulse(input int len);
        echo_rx = 1'b1;
        repeat (len) @(negedge clk);
        echo_rx = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int lens[4];
        int s;
        lens = '{9, 13, 21, 4};

        rst_n   = 1'b0;
        enable  = 1'b0;
        echo_rx = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_trig", int'(trig_tx), 0);

        // 1: asynchronous reset in the middle of a trigger pulse
        rst_n  = 1'b1;
        enable = 1'b1;
        wait_trig(1'b1, 50, n);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_trig", int'(trig_tx), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_mux", int'(mux_sensor_select), 0);
        chk("arst_valid", int'(dist_valid), 0);
        chk("arst_sensor", int'(dist_sensor), 0);
        chk("arst_us", int'(dist_us), 0);
        chk("arst_timeout", int'(dist_timeout), 0);
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_busy", int'(busy), 0);
        chk("idle_trig", int'(trig_tx), 0);

        // 2: normal echo of 162 cycles -> 40 ticks on sensor 0
        enable = 1'b1;
        wait_trig(1'b1, 50, n);
        chk("enable_to_trig", n, 9);
        chk("busy_running", int'(busy), 1);
        wait_trig(1'b0, 50, n);
        chk("trig_width", n, 5);
        push(0, 40, 0);
        echo_pulse(162);
        wait_valid(50, n);
        @(negedge clk);
        chk("mux_after_s0", int'(mux_sensor_select), 1);

        // 3: no echo -> timeout 400 cycles after the trigger ends
        wait_trig(1'b1, 50, n);
        wait_trig(1'b0, 50, n);
        push(1, 0, 1);
        wait_valid(600, n);
        chk("no_echo_latency", n, 400);

        // 4: stuck echo, then stale-high echo into the next scan, then a real toggle
        wait_trig(1'b1, 50, n);
        wait_trig(1'b0, 50, n);
        push(2, 100, 1);
        push(0, 0, 1);
        push(1, 10, 0);
        echo_pulse(1000);
        repeat (4) @(negedge clk);
        echo_pulse(40);

        // 6: drop enable mid-measure on sensor 2
        wait_trig(1'b1, 600, n);
        wait_trig(1'b0, 50, n);
        chk("mux_before_abort", int'(mux_sensor_select), 2);
        echo_rx = 1'b1;
        repeat (50) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        chk("abort_trig", int'(trig_tx), 0);
        chk("abort_mux", int'(mux_sensor_select), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_valid", int'(dist_valid), 0);
        echo_rx = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_still_idle", int'(busy), 0);

        // 5: four scans after re-enable, sensors 0,1,2,0
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s = i % 3;
            wait_trig(1'b1, 50, n);
            chk("scan_mux", int'(mux_sensor_select), s);
            wait_trig(1'b0, 50, n);
            push(s, lens[i] / 4, 0);
            echo_pulse(lens[i]);
            wait_valid(50, n);
            @(negedge clk);
            chk("scan_mux_next", int'(mux_sensor_select), (s + 1) % 3);
        end

        enable = 1'b0;
        repeat (10) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
